// File: rtl/video_sync_decoder.sv
// Video sync decoder: recovers pixel position from active-low hsync/vsync and locks after LOCK_FRAMES clean frames.
// Define FRAME_CHECKSUM_EN to add the per-frame colour checksum on frame_sum.
module video_sync_decoder #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [3:0]  pix_r,
    output logic [3:0]  pix_g,
    output logic [3:0]  pix_b,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_error,
    output logic [15:0] frame_count,
    output logic [15:0] frame_sum,
    output logic [1:0]  dbg_state
);

    // pix_valid qualifies pix_x/pix_y/pix_r/pix_g/pix_b for exactly one cycle; there is
    // no back-pressure, so the sink must take every sample presented with pix_valid=1.

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int WHOLE_LINE  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int WHOLE_FRAME = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] X_LAST = 10'(WHOLE_LINE - 1);
    localparam logic [9:0] Y_LAST = 10'(WHOLE_FRAME - 1);
    localparam logic [9:0] HS_X   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] VS_Y   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] X_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] Y_VIS  = 10'(V_VISIBLE);
    localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

    logic        hs1, vs1, hs2, vs2;
    logic [11:0] rgb1;
    logic [9:0]  x_q, y_q;
    state_t      state, state_nxt;
    logic [7:0]  good, good_nxt;

    logic        hs_fall, vs_fall, x_wrap, hs_err, vs_err, err;
    logic [9:0]  x_fw, y_fw, x_cur, y_cur;
    logic        lock_nxt, valid_nxt, fs_nxt;

    assign dbg_state = state;

    always_comb begin
        hs_fall = ~hs1 & hs2;
        vs_fall = ~vs1 & vs2;
        // Freewheel position is where the sample would be without any sync edge.
        x_wrap  = (x_q == X_LAST);
        x_fw    = x_wrap ? 10'd0 : x_q + 10'd1;
        y_fw    = y_q;
        if (x_wrap) begin
            y_fw = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
        end
        x_cur   = hs_fall ? HS_X : x_fw;
        y_cur   = vs_fall ? VS_Y : y_fw;

        hs_err  = hs_fall != (x_fw == HS_X);
        vs_err  = vs_fall != ((x_fw == 10'd0) && (y_fw == VS_Y));
        err     = (state != SEARCH) && (hs_err || vs_err);

        state_nxt = state;
        good_nxt  = good;
        case (state)
            SEARCH: begin
                if (vs_fall) begin
                    state_nxt = MEASURE;
                    good_nxt  = 8'd0;
                end
            end
            MEASURE: begin
                if (err) begin
                    state_nxt = SEARCH;
                end else if (vs_fall) begin
                    good_nxt = good + 8'd1;
                    if (good + 8'd1 >= LOCK_N) begin
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (err) begin
                    state_nxt = SEARCH;
                end
            end
            default: state_nxt = SEARCH;
        endcase

        lock_nxt  = (state_nxt == LOCKED);
        valid_nxt = lock_nxt && (x_cur < X_VIS) && (y_cur < Y_VIS);
        fs_nxt    = lock_nxt && (x_cur == 10'd0) && (y_cur == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs1         <= 1'b1;
            vs1         <= 1'b1;
            hs2         <= 1'b1;
            vs2         <= 1'b1;
            rgb1        <= 12'd0;
            x_q         <= 10'd0;
            y_q         <= 10'd0;
            state       <= SEARCH;
            good        <= 8'd0;
            pix_valid   <= 1'b0;
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            pix_r       <= 4'd0;
            pix_g       <= 4'd0;
            pix_b       <= 4'd0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_error  <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            hs1         <= hsync;
            vs1         <= vsync;
            rgb1        <= {r, g, b};
            hs2         <= hs1;
            vs2         <= vs1;
            x_q         <= x_cur;
            y_q         <= y_cur;
            state       <= state_nxt;
            good        <= good_nxt;
            pix_valid   <= valid_nxt;
            pix_x       <= x_cur;
            pix_y       <= y_cur;
            pix_r       <= valid_nxt ? rgb1[11:8] : 4'd0;
            pix_g       <= valid_nxt ? rgb1[7:4]  : 4'd0;
            pix_b       <= valid_nxt ? rgb1[3:0]  : 4'd0;
            frame_start <= fs_nxt;
            locked      <= lock_nxt;
            sync_error  <= err;
            if (fs_nxt) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] acc;

    // The (0,0) pixel opens the new frame's sum; the finished sum moves to frame_sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= 16'd0;
            frame_sum <= 16'd0;
        end else if (fs_nxt) begin
            frame_sum <= acc;
            acc       <= {4'd0, rgb1};
        end else if (valid_nxt) begin
            acc <= acc + {4'd0, rgb1};
        end
    end
`else
    assign frame_sum = 16'd0;
`endif

endmodule

// File: tb/tb_video_sync_decoder.sv
// Bench for video_sync_decoder on a reduced 16x11 raster: expected pixels and events are queued at
// drive time and popped by a monitor when the decoder presents them.
module tb_video_sync_decoder;

    localparam int HV = 8, HF = 2, HSW = 3, HB = 3;
    localparam int VV = 6, VF = 1, VSW = 2, VB = 2;
    localparam int LOCKN = 2;
    localparam int WL = HV + HF + HSW + HB;   // 16
    localparam int WF = VV + VF + VSW + VB;   // 11
    localparam int HS_X = HV + HF;            // 10
    localparam int VS_Y = VV + VF;            // 7
    localparam int FRAME = WL * WF;
    localparam int PW = 64;
    localparam int EW = 67;
    localparam logic [1:0] EV_SERR = 2'd0, EV_LFALL = 2'd1, EV_LRISE = 2'd2, EV_FS = 2'd3;
`ifdef FRAME_CHECKSUM_EN
    // r=x, g=y, b=1 over 8x6: 6*28*256 + 8*15*16 + 48
    localparam logic [15:0] FULL_SUM = 16'hAFB0;
`endif

    logic        clk, rst, hsync, vsync;
    logic [3:0]  r, g, b;
    logic        pix_valid, frame_start, locked, sync_error;
    logic [9:0]  pix_x, pix_y;
    logic [3:0]  pix_r, pix_g, pix_b;
    logic [15:0] frame_count, frame_sum;
    logic [1:0]  dbg_state;

    video_sync_decoder #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .LOCK_FRAMES(LOCKN)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .r(r), .g(g), .b(b),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .frame_start(frame_start), .locked(locked), .sync_error(sync_error),
        .frame_count(frame_count), .frame_sum(frame_sum), .dbg_state(dbg_state)
    );

    // clock / reset block
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    logic [PW-1:0] exp_q[$];   // {stamp, x, y, r, g, b}
    logic [EW-1:0] ev_q[$];    // {kind, stamp, frame_count, frame_sum, check_sum}

    int          sx, sy, vs_seen;
    logic [15:0] exp_fc, exp_sum;
    bit          exp_locked, sum_known, mon_en;
    bit          prev_locked = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic push_ev(input logic [1:0] kind, input int stamp, input logic [15:0] fc,
                           input logic [15:0] sum, input bit chk);
        ev_q.push_back({kind, 32'(stamp), fc, sum, chk});
    endtask

    // driver: one source pixel per cycle; fault 1 drops the hsync pulse on line 2,
    // fault 2 starts it one pixel early on line 2
    task automatic step(input int fault, input bit do_rst);
        logic          hs;
        int            c;
        logic [PW-1:0] tail;
        @(negedge clk);
        c  = cyc;
        hs = !(sx >= HS_X && sx < HS_X + HSW);
        if (fault == 1 && sy == 2 && sx >= HS_X && sx < HS_X + HSW) hs = 1'b1;
        if (fault == 2 && sy == 2 && sx == HS_X - 1) hs = 1'b0;
        hsync = hs;
        vsync = !(sy >= VS_Y && sy < VS_Y + VSW);
        r = 4'(sx);
        g = 4'(sy);
        b = 4'h1;
        rst = do_rst;
        if (do_rst) begin
            if (exp_locked) push_ev(EV_LFALL, c + 1, 16'd0, 16'd0, 1'b0);
            while (exp_q.size() > 0) begin
                tail = exp_q[exp_q.size() - 1];
                if (int'(tail[63:32]) >= c + 1) void'(exp_q.pop_back());
                else break;
            end
            exp_locked = 1'b0;
            vs_seen    = 0;
            exp_fc     = 16'd0;
            sum_known  = 1'b1;
            exp_sum    = 16'd0;
        end else begin
            if (exp_locked && sy == 2 &&
                ((fault == 1 && sx == HS_X) || (fault == 2 && sx == HS_X - 1))) begin
                push_ev(EV_SERR, c + 2, exp_fc, 16'd0, 1'b0);
                push_ev(EV_LFALL, c + 2, 16'd0, 16'd0, 1'b0);
                exp_locked = 1'b0;
                vs_seen    = 0;
                sum_known  = 1'b0;
            end
            if (sx == 0 && sy == VS_Y) begin
                vs_seen++;
                if (vs_seen == LOCKN + 1) begin
                    exp_locked = 1'b1;
                    push_ev(EV_LRISE, c + 2, 16'd0, 16'd0, 1'b0);
                end
            end
            if (exp_locked && sx == 0 && sy == 0) begin
                exp_fc++;
`ifdef FRAME_CHECKSUM_EN
                push_ev(EV_FS, c + 2, exp_fc, exp_sum, sum_known);
                exp_sum = FULL_SUM;
`else
                push_ev(EV_FS, c + 2, exp_fc, 16'd0, 1'b1);
`endif
            end
            if (exp_locked && sx < HV && sy < VV)
                exp_q.push_back({32'(c + 2), 10'(sx), 10'(sy), 4'(sx), 4'(sy), 4'h1});
        end
        sx++;
        if (sx == WL) begin
            sx = 0;
            sy++;
            if (sy == WF) sy = 0;
        end
    endtask

    task automatic run(input int n, input int fault);
        repeat (n) step(fault, 1'b0);
    endtask

    task automatic take_ev(input logic [1:0] kind);
        logic [EW-1:0] ee;
        if (ev_q.size() == 0) begin
            check("ev_unexpected", 128'(ev_q.size()), 128'(1));
        end else begin
            ee = ev_q.pop_front();
            check("ev_kind_time", 128'({kind, 32'(cyc)}), 128'(ee[66:33]));
            case (kind)
                EV_SERR:  check("serr_state_fc", 128'({dbg_state, frame_count}), 128'({2'd0, ee[32:17]}));
                EV_LRISE: check("lock_state", 128'(dbg_state), 128'(2'd2));
                EV_FS: begin
                    check("fs_count", 128'(frame_count), 128'(ee[32:17]));
                    if (ee[0]) check("frame_sum", 128'(frame_sum), 128'(ee[16:1]));
                end
                default: ;
            endcase
        end
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        logic [PW-1:0] pe;
        logic [EW-1:0] fe;
        #1;
        if (mon_en) begin
            while (exp_q.size() > 0 && int'(exp_q[0][63:32]) < cyc) begin
                pe = exp_q.pop_front();
                check("pix_missing", 128'(cyc), 128'(pe[63:32]));
            end
            while (ev_q.size() > 0 && int'(ev_q[0][64:33]) < cyc) begin
                fe = ev_q.pop_front();
                check("ev_missing", 128'(cyc), 128'(fe[64:33]));
            end
            if (pix_valid) begin
                if (exp_q.size() == 0) begin
                    check("pix_unexpected", 128'(exp_q.size()), 128'(1));
                end else begin
                    pe = exp_q.pop_front();
                    check("pix", 128'({32'(cyc), pix_x, pix_y, pix_r, pix_g, pix_b}), 128'(pe));
                end
            end else begin
                check("blank_rgb", 128'({pix_r, pix_g, pix_b}), 128'(0));
            end
            if (sync_error) take_ev(EV_SERR);
            if (!locked && prev_locked) take_ev(EV_LFALL);
            if (locked && !prev_locked) take_ev(EV_LRISE);
            if (frame_start) take_ev(EV_FS);
        end
        prev_locked = locked;
    end

    initial begin
        rst = 1'b1; hsync = 1'b1; vsync = 1'b1; r = 4'd0; g = 4'd0; b = 4'd0;
        sx = 0; sy = 0; vs_seen = 0; exp_fc = 16'd0; exp_sum = 16'd0;
        exp_locked = 1'b0; sum_known = 1'b1; mon_en = 1'b1;

        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        check("reset_outputs", 128'({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_start, locked,
                                     sync_error, frame_count, frame_sum, dbg_state}), 128'(0));

        // clean source from (0,0): lock on frame 2, frame_start on frames 3 and 4
        run(5 * FRAME, 0);
        // dropped hsync pulse, then relock
        run(FRAME, 1);
        run(3 * FRAME, 0);
        // early hsync pulse, then relock
        run(FRAME, 2);
        run(3 * FRAME, 0);
        // one-cycle reset at (4,3) mid-frame, then relock from scratch
        run(3 * WL + 4, 0);
        step(0, 1'b1);
        @(posedge clk);
        #2;
        check("midframe_reset_outputs", 128'({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_start,
                                              locked, sync_error, frame_count, frame_sum, dbg_state}), 128'(0));
        run(FRAME - (3 * WL + 5) + 4 * FRAME + 20, 0);

        repeat (2) @(posedge clk);
        #2;
        mon_en = 1'b0;
        check("pix_q_drained", 128'(exp_q.size()), 128'(0));
        check("ev_q_drained", 128'(ev_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/video_sync_decoder.md
VIDEO_SYNC_DECODER -- requirements
Module: video_sync_decoder

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_VISIBLE 640 active pixels; H_FRONT 16 h front porch; H_SYNC 96 hsync width; H_BACK 48 h back porch; V_VISIBLE 480 active lines; V_FRONT 10; V_SYNC 2; V_BACK 33; LOCK_FRAMES 2 good frames before lock.
REQ-002 clk  in  1  pixel clock; same clock as the video source.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 hsync, vsync  in  1 each  sync inputs, active-low.
REQ-005 r, g, b  in  4 each  pixel colour.
REQ-006 pix_valid  out  1  decoded sample is in the visible area and the decoder is locked.
REQ-007 pix_x  out  10; pix_y  out  10  decoded position.
REQ-008 pix_r, pix_g, pix_b  out  4 each  colour; 0 when pix_valid=0.
REQ-009 frame_start  out  1  one-cycle pulse with the sample at (0,0).
REQ-010 locked  out  1; sync_error  out  1 (one-cycle pulse); frame_count  out  16.
REQ-011 frame_sum  out  16  per-frame checksum (see Configuration).

Function
REQ-012 Stage 1 SHALL register hsync, vsync and rgb. Stage 2 SHALL hold the previous sync samples. All outputs SHALL be registered; input-to-output latency = 2 clk.
REQ-013 hs_fall = stage1 hsync 0 and stage2 hsync 1; vs_fall defined the same way for vsync.
REQ-014 Position of the stage-1 sample:
- x = H_VISIBLE+H_FRONT (656) on hs_fall; otherwise previous x+1, wrapping at WHOLE_LINE-1 (799) to 0.
- y increments when x wraps, wrapping 524 to 0.
- On vs_fall, y is forced to V_VISIBLE+V_FRONT (490).
REQ-015 Sync errors, detected only in MEASURE and LOCKED:
- hs_fall with freewheel x≠656, or freewheel x=656 without hs_fall.
- vs_fall with (x,y)≠(0,490), or (x,y)=(0,490) without vs_fall.
REQ-016 FSM states SEARCH, MEASURE, LOCKED; reset to SEARCH.
- SEARCH: on vs_fall go to MEASURE with good=0.
- MEASURE: error → SEARCH; each error-free vs_fall → good+1; when good reaches LOCK_FRAMES → LOCKED.
- LOCKED: error → SEARCH.
REQ-017 locked SHALL equal (state==LOCKED), delayed by the output stage.
REQ-018 sync_error SHALL pulse 1 cycle for each error in MEASURE or LOCKED; no errors are reported in SEARCH.
REQ-019 Error and lock completion in the same cycle: error wins, next state SEARCH.
REQ-020 pix_valid = locked && x<640 && y<480. pix_x and pix_y SHALL be output in all states.
REQ-021 frame_start SHALL pulse only in LOCKED, when x=0 and y=0. frame_count SHALL increment on frame_start and wrap at 65535→0.

Reset
REQ-022 While rst is high, next cycle:
- state SEARCH, good=0, x=0, y=0.
- stage registers: syncs=1, rgb=0.
- all outputs 0.
REQ-023 rst mid-frame SHALL abort lock immediately; relock requires the full SEARCH/MEASURE sequence.

Configuration
REQ-024 With FRAME_CHECKSUM_EN defined:
- the accumulator SHALL add {r,g,b} (12 bit, zero-extended, mod 2^16) for every pix_valid sample.
- On frame_start, frame_sum SHALL take the completed accumulator value, and the accumulator SHALL restart with the current pixel.
- frame_sum resets to 0.
REQ-025 Without FRAME_CHECKSUM_EN: frame_sum SHALL be tied to 0 and no accumulator logic SHALL exist.

Verification
REQ-026 Standard 640x480 source released from reset -> locked=1 two cycles after the third vs_fall; sync_error stays 0; frame_start at the next (0,0).
REQ-027 Source drives r=x[3:0] while locked -> pix_x=5 carries pix_r=5 two clocks after input; pix_r=0 at pix_x=700.
REQ-028 One hsync pulse suppressed while locked -> one sync_error pulse at expected x=656 (+2 latency); locked=0; relock after three further vs_fall.
REQ-029 hsync falls 1 clk early (x=655) -> sync_error pulse, state SEARCH; frame_count holds its value.
REQ-030 rst high for 1 cycle mid-frame -> next cycle all outputs 0 and locked=0; relock follows REQ-026.
REQ-031 FRAME_CHECKSUM_EN, constant rgb=12'h001, locked -> frame_sum=16'hB000 (307200 mod 65536) at the second frame_start.
